// File: rtl/shift_unit_pipe_if.sv
// shift_unit_pipe_if: handshake bus between the shift pipeline and its upstream/downstream
interface shift_unit_pipe_if #(
    parameter int WIDTH = 32,
    parameter int TAG_W = 5
);
    localparam int AW = $clog2(WIDTH);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic [AW-1:0]    in_amt;
    logic [1:0]       in_mode;
    logic [TAG_W-1:0] in_tag;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic [TAG_W-1:0] out_tag;
    logic             out_zero;
    modport master (
        output in_valid, in_data, in_amt, in_mode, in_tag, out_ready,
        input  in_ready, out_valid, out_data, out_tag, out_zero
    );
    modport slave (
        input  in_valid, in_data, in_amt, in_mode, in_tag, out_ready,
        output in_ready, out_valid, out_data, out_tag, out_zero
    );
endinterface

// File: rtl/shift_unit_pipe.sv
// shift_unit_pipe: pipelined SLL/SRL/SRA/ROR with log2(WIDTH) binary sub-stages over PIPE registers
module shift_unit_pipe #(
    parameter int WIDTH = 32,
    parameter int PIPE  = 2,
    parameter int TAG_W = 5
) (
    input logic           clock,
    input logic           reset_n,
    shift_unit_pipe_if.slave bus
);
    localparam int AW = $clog2(WIDTH);

    // one binary sub-stage; the sign rides along so SRA never re-reads a partial MSB
    function automatic logic [WIDTH-1:0] shf(input logic [WIDTH-1:0] d, input int sh,
                                             input logic [1:0] m, input logic sg);
        logic [WIDTH:0] t;
        t = {m == 2'b10 ? sg : 1'b0, d};
        return m == 2'b00 ? d << sh :
               m == 2'b11 ? (d >> sh) | (d << (WIDTH - sh)) :
               WIDTH'($signed(t) >>> sh);
    endfunction

    logic w_stall;
    logic r_zero;

    for (genvar s = 0; s < PIPE; s++) begin : g_st
        logic [WIDTH-1:0] w_src;
        logic [WIDTH-1:0] w_res;
        logic [AW-1:0]    w_amt;
        logic [1:0]       w_mode;
        logic             w_sign;
        logic [TAG_W-1:0] w_tag;
        logic             w_vld;
        logic [WIDTH-1:0] r_data;
        logic [TAG_W-1:0] r_tag;
        logic             r_vld;
        if (s == 0) begin : g_in
            assign w_src  = bus.in_data;
            assign w_amt  = bus.in_amt;
            assign w_mode = bus.in_mode;
            assign w_sign = bus.in_data[WIDTH-1];
            assign w_tag  = bus.in_tag;
            assign w_vld  = bus.in_valid;
        end else begin : g_mid
            assign w_src  = g_st[s-1].r_data;
            assign w_amt  = g_st[s-1].g_ctl.r_amt;
            assign w_mode = g_st[s-1].g_ctl.r_mode;
            assign w_sign = g_st[s-1].g_ctl.r_sign;
            assign w_tag  = g_st[s-1].r_tag;
            assign w_vld  = g_st[s-1].r_vld;
        end
        // apply only the sub-stages that map onto this register stage
        always_comb begin
            w_res = w_src;
            for (int k = 0; k < AW; k++)
                if (w_amt[k] && (k * PIPE) / AW == s) w_res = shf(w_res, 1 << k, w_mode, w_sign);
        end
        // advance on no stall; payload only loads behind a valid so bubbles keep old data
        always_ff @(posedge clock or negedge reset_n) begin
            if (!reset_n) begin
                r_vld  <= 1'b0;
                r_data <= '0;
                r_tag  <= '0;
            end else if (!w_stall) begin
                r_vld <= w_vld;
                if (w_vld) begin
                    r_data <= w_res;
                    r_tag  <= w_tag;
                end
            end
        end
        if (s < PIPE - 1) begin : g_ctl
            logic [AW-1:0] r_amt;
            logic [1:0]    r_mode;
            logic          r_sign;
            // control for downstream sub-stages, not needed past the last stage
            always_ff @(posedge clock or negedge reset_n) begin
                if (!reset_n) begin
                    r_amt  <= '0;
                    r_mode <= '0;
                    r_sign <= 1'b0;
                end else if (!w_stall && w_vld) begin
                    r_amt  <= w_amt;
                    r_mode <= w_mode;
                    r_sign <= w_sign;
                end
            end
        end
    end

    assign w_stall       = g_st[PIPE-1].r_vld & ~bus.out_ready;
    assign bus.in_ready  = reset_n & ~w_stall;
    assign bus.out_valid = g_st[PIPE-1].r_vld;
    assign bus.out_data  = g_st[PIPE-1].r_data;
    assign bus.out_tag   = g_st[PIPE-1].r_tag;
    assign bus.out_zero  = r_zero;

    // zero flag registered alongside the final data so it tracks out_data exactly
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) r_zero <= 1'b1;
        else if (!w_stall && g_st[PIPE-1].w_vld) r_zero <= ~|g_st[PIPE-1].w_res;
    end
endmodule
